// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: classifies {A,B} transitions, accumulates quarter-steps
// into detents and keeps a wrapping signed position count plus step/direction/error flags.
module quad_decoder #(
  parameter int CNT_W    = 8,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_FWD,
    MOVE_REV,
    MOVE_BAD
  } move_t;

  localparam logic signed [3:0] Q_MAX   = 4'(STEP_DIV - 1);
  localparam logic signed [3:0] Q_MIN   = -Q_MAX;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [1:0]        cur;
  logic [1:0]        ab_q;
  logic              primed;
  logic signed [3:0] q;
  logic [1:0]        delta;
  move_t             move;

  assign cur = {a_in, b_in};

  // Position of a code within one electrical cycle, walking the CW order 00,10,11,01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  always_comb begin
    move  = MOVE_NONE;
    delta = phase(cur) - phase(ab_q);
    case (delta)
      2'd1:    move = MOVE_FWD;
      2'd2:    move = MOVE_BAD;
      2'd3:    move = MOVE_REV;
      default: move = MOVE_NONE;
    endcase
  end

  // The first edge after reset only captures the input levels, so release never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q       <= 2'b00;
      primed     <= 1'b0;
      q          <= '0;
      count      <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      ab_q <= cur;
      step <= 1'b0;
      err  <= 1'b0;
      if (!primed) begin
        primed <= 1'b1;
      end else if (clear) begin
        count      <= '0;
        q          <= '0;
        err_sticky <= 1'b0;
      end else begin
        case (move)
          MOVE_FWD: begin
            if (q == Q_MAX) begin
              q     <= '0;
              count <= count + CNT_ONE;
              step  <= 1'b1;
              dir   <= 1'b1;
            end else begin
              q <= q + 4'sd1;
            end
          end
          MOVE_REV: begin
            if (q == Q_MIN) begin
              q     <= '0;
              count <= count - CNT_ONE;
              step  <= 1'b1;
              dir   <= 1'b0;
            end else begin
              q <= q - 4'sd1;
            end
          end
          MOVE_BAD: begin
            err        <= 1'b1;
            err_sticky <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: two instances (8-bit/4-quarter and 4-bit/1-quarter) driven by
// directed scenarios and random {A,B} traffic, compared against a sequence-level model.
module tb_quad_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, a, b, clear;
  logic [7:0] count0;
  logic       step0, dir0, err0, sticky0;
  logic [3:0] count1;
  logic       step1, dir1, err1, sticky1;

  quad_decoder #(.CNT_W(8), .STEP_DIV(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .clear(clear),
    .count(count0), .step(step0), .dir(dir0), .err(err0), .err_sticky(sticky0)
  );

  quad_decoder #(.CNT_W(4), .STEP_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b), .clear(clear),
    .count(count1), .step(step1), .dir(dir1), .err(err1), .err_sticky(sticky1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per instance
  int         divs[2] = '{4, 1};
  int         mQ[2], mCount[2], stepTotal[2], errTotal[2];
  bit         mDir[2], mSticky[2], mStep[2], mErr[2], mPrimed[2];
  logic [1:0] mPrev[2];

  function automatic logic [1:0] cwNext(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccwNext(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mQ[i] = 0; mCount[i] = 0; mDir[i] = 0; mSticky[i] = 0;
      mStep[i] = 0; mErr[i] = 0; mPrimed[i] = 0; mPrev[i] = 2'b00;
    end
  endtask

  task automatic modelStep(input logic [1:0] cur, input logic clr);
    for (int i = 0; i < 2; i++) begin
      mStep[i] = 0;
      mErr[i]  = 0;
      if (!mPrimed[i]) begin
        mPrimed[i] = 1;
      end else if (clr) begin
        mCount[i] = 0; mQ[i] = 0; mSticky[i] = 0;
      end else if (cur == cwNext(mPrev[i])) begin
        mQ[i]++;
        if (mQ[i] == divs[i]) begin
          mQ[i] = 0; mCount[i]++; mStep[i] = 1; mDir[i] = 1;
        end
      end else if (cur == ccwNext(mPrev[i])) begin
        mQ[i]--;
        if (mQ[i] == -divs[i]) begin
          mQ[i] = 0; mCount[i]--; mStep[i] = 1; mDir[i] = 0;
        end
      end else if (cur != mPrev[i]) begin
        mErr[i] = 1; mSticky[i] = 1;
      end
      mPrev[i] = cur;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] c0, c1;
    c0 = 32'(mCount[0]) & 32'hFF;
    c1 = 32'(mCount[1]) & 32'hF;
    checkValue({tag, ".count0"},  {24'd0, count0}, c0);
    checkValue({tag, ".step0"},   {31'd0, step0},   {31'd0, mStep[0]});
    checkValue({tag, ".dir0"},    {31'd0, dir0},    {31'd0, mDir[0]});
    checkValue({tag, ".err0"},    {31'd0, err0},    {31'd0, mErr[0]});
    checkValue({tag, ".sticky0"}, {31'd0, sticky0}, {31'd0, mSticky[0]});
    checkValue({tag, ".count1"},  {28'd0, count1},  c1);
    checkValue({tag, ".step1"},   {31'd0, step1},   {31'd0, mStep[1]});
    checkValue({tag, ".dir1"},    {31'd0, dir1},    {31'd0, mDir[1]});
    checkValue({tag, ".err1"},    {31'd0, err1},    {31'd0, mErr[1]});
    checkValue({tag, ".sticky1"}, {31'd0, sticky1}, {31'd0, mSticky[1]});
    checkValue({tag, ".excl0"},   {31'd0, step0 & err0}, 32'd0);
    stepTotal[0] += int'(step0); stepTotal[1] += int'(step1);
    errTotal[0]  += int'(err0);  errTotal[1]  += int'(err1);
  endtask

  // Drive one clock's worth of inputs, advance the model, then sample after the edge
  task automatic applyStimulus(input logic [1:0] cur, input logic clr, input string tag);
    @(negedge clk);
    {a, b} = cur;
    clear  = clr;
    @(posedge clk);
    modelStep(cur, clr);
    #1;
    checkOutput(tag);
  endtask

  task automatic holdStimulus(input logic [1:0] cur, input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(cur, 1'b0, tag);
  endtask

  task automatic cwDetent(input string tag);
    applyStimulus(2'b10, 1'b0, tag);
    applyStimulus(2'b11, 1'b0, tag);
    applyStimulus(2'b01, 1'b0, tag);
    applyStimulus(2'b00, 1'b0, tag);
  endtask

  task automatic clearTallies();
    stepTotal[0] = 0; stepTotal[1] = 0; errTotal[0] = 0; errTotal[1] = 0;
  endtask

  initial begin
    logic [1:0] seq[4];
    logic [1:0] r;

    rst_n = 1'b0; a = 1'b0; b = 1'b0; clear = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
    holdStimulus(2'b00, 3, "idle");

    // CW detent, each code held 3 clocks
    clearTallies();
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    foreach (seq[i]) holdStimulus(seq[i], 3, "cw_detent");
    checkValue("cw_count", {24'd0, count0}, 32'd1);
    checkValue("cw_dir", {31'd0, dir0}, 32'd1);
    checkValue("cw_steps", 32'(stepTotal[0]), 32'd1);
    checkValue("cw_errs", 32'(errTotal[0]), 32'd0);

    // CCW from zero wraps to all-ones, then four CW detents
    applyStimulus(2'b00, 1'b1, "pre_clear");
    clearTallies();
    applyStimulus(2'b01, 1'b0, "ccw");
    applyStimulus(2'b11, 1'b0, "ccw");
    applyStimulus(2'b10, 1'b0, "ccw");
    applyStimulus(2'b00, 1'b0, "ccw");
    checkValue("ccw_wrap", {24'd0, count0}, 32'hFF);
    checkValue("ccw_dir", {31'd0, dir0}, 32'd0);
    checkValue("ccw_steps", 32'(stepTotal[0]), 32'd1);
    for (int k = 0; k < 4; k++) cwDetent("cw4");
    checkValue("cw4_count", {24'd0, count0}, 32'h03);

    // Reversal mid-detent unwinds silently
    clearTallies();
    applyStimulus(2'b10, 1'b0, "rev");
    applyStimulus(2'b11, 1'b0, "rev");
    applyStimulus(2'b10, 1'b0, "rev");
    applyStimulus(2'b00, 1'b0, "rev");
    checkValue("rev_count", {24'd0, count0}, 32'h03);
    checkValue("rev_steps", 32'(stepTotal[0]), 32'd0);
    cwDetent("rev_after");
    checkValue("rev_after_count", {24'd0, count0}, 32'h04);

    // Illegal jump 00 -> 11
    applyStimulus(2'b11, 1'b0, "illegal");
    checkValue("illegal_err", {31'd0, err0}, 32'd1);
    applyStimulus(2'b11, 1'b0, "illegal_hold");
    checkValue("illegal_err_pulse", {31'd0, err0}, 32'd0);
    checkValue("illegal_sticky", {31'd0, sticky0}, 32'd1);
    checkValue("illegal_count", {24'd0, count0}, 32'h04);
    // Sustained clear while walking back to 00 discards those moves
    applyStimulus(2'b11, 1'b1, "clear");
    checkValue("clear_sticky", {31'd0, sticky0}, 32'd0);
    checkValue("clear_count", {24'd0, count0}, 32'd0);
    applyStimulus(2'b10, 1'b1, "clear_hold");
    applyStimulus(2'b00, 1'b1, "clear_hold");
    checkValue("clear_hold_count", {24'd0, count0}, 32'd0);

    // Clear collides with the completing CW quarter-step
    applyStimulus(2'b10, 1'b0, "collide");
    applyStimulus(2'b11, 1'b0, "collide");
    applyStimulus(2'b01, 1'b0, "collide");
    applyStimulus(2'b00, 1'b1, "collide");
    checkValue("collide_count", {24'd0, count0}, 32'd0);
    checkValue("collide_step", {31'd0, step0}, 32'd0);
    cwDetent("collide_after");
    checkValue("collide_after_count", {24'd0, count0}, 32'd1);

    // Asynchronous reset mid-cycle at count 5, then release with inputs at 11
    for (int k = 0; k < 4; k++) cwDetent("to5");
    checkValue("to5_count", {24'd0, count0}, 32'd5);
    applyStimulus(2'b10, 1'b0, "partial");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    checkValue("async_reset_count", {24'd0, count0}, 32'd0);
    {a, b} = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b11, 1'b0, "prime");
    checkValue("prime_err", {31'd0, err0}, 32'd0);
    checkValue("prime_step", {31'd0, step0}, 32'd0);
    applyStimulus(2'b01, 1'b0, "post_reset");
    applyStimulus(2'b00, 1'b0, "post_reset");
    applyStimulus(2'b10, 1'b0, "post_reset");
    applyStimulus(2'b11, 1'b0, "post_reset");
    checkValue("post_reset_count", {24'd0, count0}, 32'd1);

    // Single-quarter instance: 16 CW quarters wrap a 4-bit count back to 0
    applyStimulus(2'b11, 1'b1, "div1_clear");
    clearTallies();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 1'b0, "div1");
      applyStimulus(2'b00, 1'b0, "div1");
      applyStimulus(2'b10, 1'b0, "div1");
      applyStimulus(2'b11, 1'b0, "div1");
    end
    checkValue("div1_steps", 32'(stepTotal[1]), 32'd16);
    checkValue("div1_count", {28'd0, count1}, 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      r = 2'($urandom_range(0, 3));
      applyStimulus(r, ($urandom_range(0, 24) == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
